// File: rtl/turn_signal_sequencer_pkg.sv
// Shared encodings for the turn signal sequencer: mode codes
// and the 3-lamp patterns used by the lamp decoder.
package turn_signal_sequencer_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    localparam logic [2:0] PAT_STEP0 = 3'b000;
    localparam logic [2:0] PAT_STEP1 = 3'b001;
    localparam logic [2:0] PAT_STEP2 = 3'b011;
    localparam logic [2:0] PAT_STEP3 = 3'b111;

    localparam logic [2:0] ALL_ON  = 3'b111;
    localparam logic [2:0] ALL_OFF = 3'b000;

    // Sweep grows outward from the innermost lamp (bit0).
    function automatic logic [2:0] step_pattern(
        input logic [1:0] s
    );
        logic [2:0] p;
        case (s)
            2'd0:    p = PAT_STEP0;
            2'd1:    p = PAT_STEP1;
            2'd2:    p = PAT_STEP2;
            default: p = PAT_STEP3;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] brake_pattern(
        input logic b
    );
        return b ? ALL_ON : ALL_OFF;
    endfunction

endpackage

// File: rtl/turn_signal_sequencer_step_timer.sv
// Free-running prescaler producing a one-cycle tick every
// TICK_DIV clocks, restarting from zero on reset.
module step_timer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    assign last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = last;

endmodule

// File: rtl/turn_signal_sequencer.sv
// Turn signal sequencer: tick-paced mode/step FSM with a
// registered per-cycle lamp decode (brake acts between ticks).
module turn_signal_sequencer
    import turn_signal_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake,
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r,
    output logic [1:0] mode,
    output logic [1:0] step
);

    logic       tick;
    logic [1:0] req_mode;

    logic [1:0] mode_q;
    logic [1:0] mode_d;
    logic [1:0] step_q;
    logic [1:0] step_d;

    logic [2:0] lamp_l_q;
    logic [2:0] lamp_l_d;
    logic [2:0] lamp_r_q;
    logic [2:0] lamp_r_d;

    step_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        req_mode = MODE_IDLE;
        if (hazard_req) begin
            req_mode = MODE_HAZARD;
        end else if (left_req && !right_req) begin
            req_mode = MODE_LEFT;
        end else if (right_req && !left_req) begin
            req_mode = MODE_RIGHT;
        end
    end

    // A mode switch restarts the sweep at step 1 so the first
    // lamp lights immediately, with no dark IDLE gap.
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (tick) begin
            if (req_mode != mode_q) begin
                mode_d = req_mode;
                step_d = (req_mode == MODE_IDLE) ? 2'd0 : 2'd1;
            end else if (mode_q != MODE_IDLE) begin
                step_d = step_q + 2'd1;
            end else begin
                step_d = 2'd0;
            end
        end
    end

    always_comb begin
        lamp_l_d = ALL_OFF;
        lamp_r_d = ALL_OFF;
        case (mode_q)
            MODE_LEFT: begin
                lamp_l_d = step_pattern(step_q);
                lamp_r_d = brake_pattern(brake);
            end
            MODE_RIGHT: begin
                lamp_l_d = brake_pattern(brake);
                lamp_r_d = step_pattern(step_q);
            end
            MODE_HAZARD: begin
                lamp_l_d = step_q[0] ? ALL_ON : ALL_OFF;
                lamp_r_d = step_q[0] ? ALL_ON : ALL_OFF;
            end
            default: begin
                lamp_l_d = brake_pattern(brake);
                lamp_r_d = brake_pattern(brake);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_IDLE;
            step_q <= 2'd0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_l_q <= ALL_OFF;
            lamp_r_q <= ALL_OFF;
        end else begin
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
        end
    end

    assign mode   = mode_q;
    assign step   = step_q;
    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;

endmodule

// File: doc/turn_signal_sequencer.md
TURN_SIGNAL_SEQUENCER -- requirements
Module: turn_signal_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, clk cycles per sequence step (legal range 2..65535).
REQ-002 Parameter CNT_W, default 16, prescaler width; SHALL hold TICK_DIV-1.
REQ-003 clk  input  1  system clock; all registers update on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 left_req  input  1  left turn switch, level.
REQ-006 right_req  input  1  right turn switch, level.
REQ-007 hazard_req  input  1  hazard switch, level.
REQ-008 brake  input  1  brake pedal, level.
REQ-009 lamp_l  output  3  left lamps, bit0 innermost, registered.
REQ-010 lamp_r  output  3  right lamps, bit0 innermost, registered.
REQ-011 mode  output  2  current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.
REQ-012 step  output  2  current sequence step, 0..3.

Function
REQ-013 Prescaler free-runs 0..TICK_DIV-1 and wraps; tick SHALL be high exactly when count = TICK_DIV-1.
REQ-014 mode/step SHALL change only on a clock edge where tick is high; request changes between ticks SHALL be ignored until the next tick.
REQ-015 Requested mode at tick: hazard_req=1 -> HAZARD; else left_req XOR right_req -> LEFT/RIGHT accordingly; else (neither or both) -> IDLE.
REQ-016 On tick with requested mode = current mode != IDLE: step := step+1 mod 4 (3 wraps to 0).
REQ-017 On tick with requested mode != current mode: mode := requested; step := 1 if new mode != IDLE, else 0 (direct LEFT<->RIGHT/HAZARD switching permitted, no IDLE gap).
REQ-018 In IDLE step SHALL stay 0.
REQ-019 Turn pattern by step: 0->000, 1->001, 2->011, 3->111 on the turning side.
REQ-020 HAZARD: both sides 111 when step[0]=1, 000 when step[0]=0; brake ignored.
REQ-021 LEFT: non-turning side lamp_r = 111 if brake else 000; RIGHT symmetric for lamp_l.
REQ-022 IDLE: both sides 111 if brake else 000.
REQ-023 lamp_l/lamp_r SHALL be registered every cycle (not tick-gated) from current mode, step, brake: one-cycle latency from brake and from mode/step change.
REQ-024 mode and step outputs SHALL be the state registers directly (zero added latency).

Reset
REQ-025 While reset high: prescaler=0, mode=IDLE, step=0, lamp_l=000, lamp_r=000, regardless of clk.
REQ-026 Reset asserted mid-sequence SHALL clear immediately; after release first tick occurs on the TICK_DIV-th rising edge.
REQ-027 No input synchronization state survives reset; behaviour after release depends only on inputs.

Structure
REQ-028 Shared package SHALL hold mode encodings (IDLE/LEFT/RIGHT/HAZARD) and 3-bit lamp pattern constants for steps 0..3 and ALL_ON/ALL_OFF.
REQ-029 Prescaler SHALL be a separate sub-module step_timer (params TICK_DIV, CNT_W; ports clk, reset, tick).
REQ-030 FSM and lamp decode SHALL live in turn_signal_sequencer; decode combinational, feeding lamp registers.

Verification (TICK_DIV=4)
REQ-031 Reset release, left_req=1 held -> ticks at edges 4,8,12,16,20: mode=01, step 1,2,3,0,1; lamp_l one cycle later 001,011,111,000,001; lamp_r=000.
REQ-032 left_req=right_req=1, brake=1 -> mode stays 00, step 0, lamp_l=lamp_r=111 one cycle after brake rises; brake low -> 000 next cycle.
REQ-033 LEFT at step 2, right_req=1/left_req=0 mid-period -> no change until next tick; then mode=10, step=1, lamp_r=001, lamp_l=000 (brake=0).
REQ-034 RIGHT running, hazard_req=1 with brake=1 -> next tick mode=11, step=1, both 111; next tick both 000; brake without effect.
REQ-035 LEFT at step 3, reset pulse between edges -> lamps 000, mode 00, step 0 immediately without clk edge; step_timer restarts at 0.
REQ-036 Held hazard_req for 12 ticks -> lamps alternate 111/000 each tick, step wraps 3->0 without glitching either side.
